riscv_data_bus: RTL

Data-side interconnect sitting directly downstream of the RV32I core's data port. It decodes each load/store into an on-chip RAM or a machine-timer register window, aligns byte and half lanes, and detects misaligned or unmapped accesses. The timer's compare interrupt drives the core's `irq` input. Reads complete combinationally in the same cycle, because the core is single-cycle and has no stall.

---
 rtl/riscv_bus_pkg.sv | 39 +++
 rtl/riscv_data_bus_if.sv | 27 ++
 rtl/machine_timer.sv | 90 +++++++++
 rtl/riscv_data_bus.sv | 129 ++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_pkg
//  Description : Shared encodings for the RV32I data-side interconnect:
//                access widths, timer register word offsets, CTRL bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_bus_pkg;

    // Access width encodings driven by the core
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;
    localparam logic [1:0] WIDTH_IDLE = 2'd3;

    // Timer register word offsets (byte offset / 4)
    localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
    localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
    localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TMR_CTRL        = 3'd4;
    localparam logic [2:0] TMR_PRESCALE    = 3'd5;

    // CTRL register bit positions
    localparam int CTRL_EN           = 0;
    localparam int CTRL_ERR_MISALIGN = 1;
    localparam int CTRL_ERR_UNMAPPED = 2;

    // Keep only the bytes covered by an access of the given width
    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 32'h0000_00FF;
            WIDTH_HALF: return 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_data_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_bus_if
//  Description : Core data port bundle: address/width/strobes/store data
//                toward the interconnect, load data and irq back to the core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_data_bus_if;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_in;
    logic        irq;

    modport master (
        output data_address, data_width, data_out, data_read, data_write,
        input  data_in, irq
    );

    modport slave (
        input  data_address, data_width, data_out, data_read, data_write,
        output data_in, irq
    );
endinterface
`default_nettype wire

// File: rtl/machine_timer.sv
`default_nettype none
// ============================================================================
//  Module      : machine_timer
//  Description : 64-bit mtime/mtimecmp pair with prescaler, enable bit and a
//                registered compare interrupt, behind a word-offset port.
//  Revision    : 1.0 - initial release
// ============================================================================
module machine_timer
    import riscv_bus_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [2:0]  reg_offset,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        irq
);
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [15:0] r_prescale;
    logic [15:0] r_count;
    logic        r_irq;

    logic w_tick;
    logic w_wr_mtime_lo, w_wr_mtime_hi, w_wr_cmp_lo, w_wr_cmp_hi, w_wr_ctrl, w_wr_prescale;

    assign w_tick        = r_en && (r_count == r_prescale);
    assign w_wr_mtime_lo = reg_write && (reg_offset == TMR_MTIME_LO);
    assign w_wr_mtime_hi = reg_write && (reg_offset == TMR_MTIME_HI);
    assign w_wr_cmp_lo   = reg_write && (reg_offset == TMR_MTIMECMP_LO);
    assign w_wr_cmp_hi   = reg_write && (reg_offset == TMR_MTIMECMP_HI);
    assign w_wr_ctrl     = reg_write && (reg_offset == TMR_CTRL);
    assign w_wr_prescale = reg_write && (reg_offset == TMR_PRESCALE);

    // Counter, compare, prescaler and interrupt state; a software write to
    // either mtime half takes priority and swallows that cycle's tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_en       <= 1'b0;
            r_prescale <= PRESCALE_RESET;
            r_count    <= 16'd0;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);

            if (w_wr_prescale) begin
                r_count <= 16'd0;
            end else if (r_en) begin
                r_count <= w_tick ? 16'd0 : r_count + 16'd1;
            end

            if (w_wr_mtime_lo) begin
                r_mtime[31:0] <= reg_wdata;
            end else if (w_wr_mtime_hi) begin
                r_mtime[63:32] <= reg_wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr_cmp_lo)   r_mtimecmp[31:0]  <= reg_wdata;
            if (w_wr_cmp_hi)   r_mtimecmp[63:32] <= reg_wdata;
            if (w_wr_ctrl)     r_en              <= reg_wdata[CTRL_EN];
            if (w_wr_prescale) r_prescale        <= reg_wdata[15:0];
        end
    end

    // Register read mux; error bits of CTRL are merged in by the bus
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_offset)
            TMR_MTIME_LO:    reg_rdata = r_mtime[31:0];
            TMR_MTIME_HI:    reg_rdata = r_mtime[63:32];
            TMR_MTIMECMP_LO: reg_rdata = r_mtimecmp[31:0];
            TMR_MTIMECMP_HI: reg_rdata = r_mtimecmp[63:32];
            TMR_CTRL:        reg_rdata[CTRL_EN] = r_en;
            TMR_PRESCALE:    reg_rdata = {16'd0, r_prescale};
            default:         reg_rdata = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/riscv_data_bus.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_bus
//  Description : Data-side interconnect for the single-cycle RV32I core:
//                decodes RAM / timer window, aligns lanes, flags misaligned
//                and unmapped accesses. Loads are combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_data_bus
    import riscv_bus_pkg::*;
#(
    parameter int          RAM_WORDS      = 1024,
    parameter logic [31:0] TIMER_BASE     = 32'h0200_0000,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic            clock,
    input  logic            reset,
    riscv_data_bus_if.slave bus
);
    localparam int c_IDX_BITS = $clog2(RAM_WORDS);

    logic [31:0] r_mem [RAM_WORDS];
    logic        r_err_misalign;
    logic        r_err_unmapped;

    logic                  w_active, w_ram_hit, w_tmr_hit, w_misalign, w_unmapped, w_ok;
    logic                  w_ram_we, w_tmr_we, w_ctrl_we, w_irq;
    logic [1:0]            w_lane;
    logic [2:0]            w_tmr_offset;
    logic [c_IDX_BITS-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata, w_ram_word, w_ram_rdata, w_tmr_rdata, w_reg_rdata;

    assign w_lane       = bus.data_address[1:0];
    assign w_idx        = bus.data_address[c_IDX_BITS+1:2];
    assign w_tmr_offset = bus.data_address[4:2];

    assign w_active  = (bus.data_width != WIDTH_IDLE) && (bus.data_read || bus.data_write);
    assign w_ram_hit = (bus.data_address[31:c_IDX_BITS+2] == '0);
    // Window is 32 bytes wide but only the first six words are registers
    assign w_tmr_hit = (bus.data_address[31:5] == TIMER_BASE[31:5]) &&
                       (w_tmr_offset <= TMR_PRESCALE);

    // Alignment check; timer registers accept aligned word accesses only
    always_comb begin
        w_misalign = 1'b0;
        if (w_ram_hit) begin
            w_misalign = ((bus.data_width == WIDTH_HALF) && w_lane[0]) ||
                         ((bus.data_width == WIDTH_WORD) && (w_lane != 2'b00));
        end else if (w_tmr_hit) begin
            w_misalign = (bus.data_width != WIDTH_WORD) || (w_lane != 2'b00);
        end
    end

    assign w_unmapped = !w_ram_hit && !w_tmr_hit;
    assign w_ok       = w_active && !w_unmapped && !w_misalign;
    // A cycle with both strobes is a write; its read data is the old value
    assign w_ram_we   = w_ok && w_ram_hit && bus.data_write;
    assign w_tmr_we   = w_ok && w_tmr_hit && bus.data_write;
    assign w_ctrl_we  = w_tmr_we && (w_tmr_offset == TMR_CTRL);

    // Byte enables for the store lanes
    always_comb begin
        w_be = 4'h0;
        case (bus.data_width)
            WIDTH_BYTE: w_be = 4'b0001 << w_lane;
            WIDTH_HALF: w_be = 4'b0011 << w_lane;
            WIDTH_WORD: w_be = 4'hF;
            default:    w_be = 4'h0;
        endcase
    end

    assign w_wdata     = bus.data_out << {w_lane, 3'b000};
    assign w_ram_word  = r_mem[w_idx];
    assign w_ram_rdata = (w_ram_word >> {w_lane, 3'b000}) & width_mask(bus.data_width);

    // RAM store, byte-lane masked; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (!reset && w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Sticky error flags; a new error beats a same-cycle write-1-clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_misalign <= 1'b0;
            r_err_unmapped <= 1'b0;
        end else begin
            if (w_active && w_misalign)
                r_err_misalign <= 1'b1;
            else if (w_ctrl_we && bus.data_out[CTRL_ERR_MISALIGN])
                r_err_misalign <= 1'b0;

            if (w_active && w_unmapped)
                r_err_unmapped <= 1'b1;
            else if (w_ctrl_we && bus.data_out[CTRL_ERR_UNMAPPED])
                r_err_unmapped <= 1'b0;
        end
    end

    machine_timer #(
        .PRESCALE_RESET(PRESCALE_RESET)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .reg_write  (w_tmr_we),
        .reg_offset (w_tmr_offset),
        .reg_wdata  (bus.data_out),
        .reg_rdata  (w_tmr_rdata),
        .irq        (w_irq)
    );

    // CTRL read combines the timer's EN with the bus error flags
    always_comb begin
        w_reg_rdata = w_tmr_rdata;
        if (w_tmr_offset == TMR_CTRL) begin
            w_reg_rdata[CTRL_ERR_MISALIGN] = r_err_misalign;
            w_reg_rdata[CTRL_ERR_UNMAPPED] = r_err_unmapped;
        end
    end

    assign bus.data_in = (w_ok && bus.data_read) ? (w_ram_hit ? w_ram_rdata : w_reg_rdata) : 32'd0;
    assign bus.irq     = w_irq;

endmodule
`default_nettype wire
